// File: rtl/analyzer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : analyzer_sequencer
//  Purpose  : Front-end controller for the number_analyzer. Buffers incoming
//             numbers in a small FIFO, launches one analysis at a time
//             (number + one-cycle restart pulse), waits for the analyzer's
//             ready (with timeout) and presents the flags on a valid/ready
//             result port.
//  Ports    : clock/reset        - rising-edge clock, sync active-low reset
//             in_valid/in_ready/in_number     - input number stream
//             ana_number/ana_restart/ana_enable - drive to the analyzer
//             ana_ready/ana_is_odd/ana_is_fib/ana_is_pal - from the analyzer
//             out_valid/out_ready/out_number/out_flags/out_timeout - results
//             busy       - work in flight or queued
//             done_count - number of results handed off (wraps)
//  Revision : 1.0 - initial release
// ============================================================================
module analyzer_sequencer #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_number,
    output logic [WIDTH-1:0] ana_number,
    output logic             ana_restart,
    output logic             ana_enable,
    input  logic             ana_ready,
    input  logic             ana_is_odd,
    input  logic             ana_is_fib,
    input  logic             ana_is_pal,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_number,
    output logic [2:0]       out_flags,
    output logic             out_timeout,
    output logic             busy,
    output logic [15:0]      done_count
);

    localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_MAX    = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
    localparam int TW         = $clog2(CNT_MAX + 1);
    localparam logic [AW:0]   FULL_COUNT   = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] SETTLE_LAST  = TW'(SETTLE - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_SETTLE = 3'd2,
        S_WAIT   = 3'd3,
        S_EMIT   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_push;
    logic              w_pop;

    logic [TW-1:0]     r_timer;
    logic              w_settle_done;
    logic              w_expired;

    logic [WIDTH-1:0]  r_ana_number;
    logic [WIDTH-1:0]  r_out_number;
    logic [2:0]        r_out_flags;
    logic              r_out_timeout;
    logic [15:0]       r_done_count;

    // ------------------------------------------------------------------
    // Input FIFO. Pointers wrap naturally because DEPTH is a power of two.
    // ------------------------------------------------------------------
    assign in_ready = (r_count != FULL_COUNT);
    assign w_push   = in_valid && in_ready;
    assign w_pop    = (r_state == S_LAUNCH);

    // Storage has no reset; validity is tracked by r_count alone.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_number;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    assign w_settle_done = (r_timer == SETTLE_LAST);
    assign w_expired     = (r_timer == TIMEOUT_LAST);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (r_count != '0) w_next_state = S_LAUNCH;
            S_LAUNCH: w_next_state = S_SETTLE;
            S_SETTLE: if (w_settle_done) w_next_state = S_WAIT;
            // A ready arriving on the expiry cycle is still a real result,
            // so both paths lead to EMIT and the capture below prefers ready.
            S_WAIT:   if (ana_ready || w_expired) w_next_state = S_EMIT;
            S_EMIT:   if (out_ready) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Datapath: shared SETTLE/WAIT timer, analyzer number, result capture.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_timer       <= '0;
            r_ana_number  <= '0;
            r_out_number  <= '0;
            r_out_flags   <= '0;
            r_out_timeout <= 1'b0;
            r_done_count  <= '0;
        end else begin
            case (r_state)
                S_LAUNCH: begin
                    r_ana_number <= r_mem[r_rd_ptr];
                    r_timer      <= '0;
                end
                S_SETTLE: begin
                    r_timer <= w_settle_done ? '0 : r_timer + TW'(1);
                end
                S_WAIT: begin
                    if (ana_ready) begin
                        r_out_flags   <= {ana_is_pal, ana_is_fib, ana_is_odd};
                        r_out_timeout <= 1'b0;
                        r_out_number  <= r_ana_number;
                        r_timer       <= '0;
                    end else if (w_expired) begin
                        r_out_flags   <= '0;
                        r_out_timeout <= 1'b1;
                        r_out_number  <= r_ana_number;
                        r_timer       <= '0;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        r_done_count <= r_done_count + 16'd1;
                    end
                end
                default: begin
                    r_timer <= '0;
                end
            endcase
        end
    end

    assign ana_number  = r_ana_number;
    assign ana_restart = (r_state == S_LAUNCH);
    assign ana_enable  = (r_state == S_LAUNCH) || (r_state == S_SETTLE) ||
                         (r_state == S_WAIT);
    assign out_valid   = (r_state == S_EMIT);
    assign out_number  = r_out_number;
    assign out_flags   = r_out_flags;
    assign out_timeout = r_out_timeout;
    assign busy        = (r_state != S_IDLE) || (r_count != '0);
    assign done_count  = r_done_count;

endmodule
`default_nettype wire

// File: tb/tb_analyzer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_analyzer_sequencer
//  Purpose  : Directed self-checking bench for analyzer_sequencer, driven
//             against a stub analyzer that raises ana_ready a programmed
//             number of cycles after ana_restart with programmed flags.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_analyzer_sequencer;

    localparam int TO = 24;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_number;
    logic [31:0] ana_number;
    logic        ana_restart;
    logic        ana_enable;
    logic        ana_ready;
    logic        ana_is_odd;
    logic        ana_is_fib;
    logic        ana_is_pal;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_number;
    logic [2:0]  out_flags;
    logic        out_timeout;
    logic        busy;
    logic [15:0] done_count;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    analyzer_sequencer #(
        .WIDTH  (32),
        .DEPTH  (4),
        .SETTLE (2),
        .TIMEOUT(TO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_number  (in_number),
        .ana_number (ana_number),
        .ana_restart(ana_restart),
        .ana_enable (ana_enable),
        .ana_ready  (ana_ready),
        .ana_is_odd (ana_is_odd),
        .ana_is_fib (ana_is_fib),
        .ana_is_pal (ana_is_pal),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_number (out_number),
        .out_flags  (out_flags),
        .out_timeout(out_timeout),
        .busy       (busy),
        .done_count (done_count)
    );

    // Stub analyzer: stub_cnt is 1 in the cycle after the restart pulse.
    // stub_n == 0 means it never becomes ready; stub_stale adds a spurious
    // ready in that first cycle.
    logic [7:0] stub_cnt = 8'd0;
    int         stub_n;
    logic       stub_stale;
    logic [2:0] stub_flags;

    always @(posedge clock) begin
        if (ana_restart) stub_cnt <= 8'd1;
        else if (stub_cnt != 8'd0 && stub_cnt != 8'hFF) stub_cnt <= stub_cnt + 8'd1;
    end

    assign ana_ready  = (stub_stale && stub_cnt == 8'd1) ||
                        (stub_n != 0 && int'(stub_cnt) >= stub_n);
    assign ana_is_odd = stub_flags[0];
    assign ana_is_fib = stub_flags[1];
    assign ana_is_pal = stub_flags[2];

    // Monitors
    int          restart_cnt = 0;
    int          full_cycles = 0;
    logic [31:0] got_q[$];

    always @(posedge clock) begin
        if (ana_restart) restart_cnt <= restart_cnt + 1;
        if (reset && !in_ready) full_cycles <= full_cycles + 1;
        if (out_valid && out_ready) got_q.push_back(out_number);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        int g;
        g = 0;
        in_valid  = 1'b1;
        in_number = w;
        while (!in_ready && g < 200) begin
            step;
            g++;
        end
        step;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int max, output int cyc);
        cyc = 0;
        while (!out_valid && cyc < max) begin
            step;
            cyc++;
        end
    endtask

    task automatic wait_restart;
        int g;
        g = 0;
        while (!ana_restart && g < 50) begin
            step;
            g++;
        end
    endtask

    task automatic consume;
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          cyc;
        int          rc;
        int          fc;
        int          base;
        int          g;
        logic        stable;
        logic [31:0] words [5];

        words[0] = 32'd1346269;
        words[1] = 32'd1187811;
        words[2] = 32'd832040;
        words[3] = 32'd13469;
        words[4] = 32'd1669;

        reset      = 1'b0;
        in_valid   = 1'b0;
        in_number  = '0;
        out_ready  = 1'b0;
        stub_n     = 0;
        stub_stale = 1'b0;
        stub_flags = 3'b000;
        step;
        step;

        // ---- reset state ----
        check("rst_in_ready",   32'(in_ready), 32'd1);
        check("rst_out_valid",  32'(out_valid), 32'd0);
        check("rst_ana_number", ana_number, 32'd0);
        check("rst_done_count", 32'(done_count), 32'd0);
        check("rst_busy",       32'(busy), 32'd0);
        check("rst_enable",     32'(ana_enable), 32'd0);
        check("rst_restart",    32'(ana_restart), 32'd0);
        reset = 1'b1;
        step;

        // ---- single word, N=20, flags 011 ----
        stub_n     = 20;
        stub_flags = 3'b011;
        rc         = restart_cnt;
        push(32'd1346269);
        check("t1_busy_queued", 32'(busy), 32'd1);
        step;
        check("t1_restart_hi",  32'(ana_restart), 32'd1);
        check("t1_enable",      32'(ana_enable), 32'd1);
        step;
        check("t1_restart_lo",  32'(ana_restart), 32'd0);
        check("t1_ana_number",  ana_number, 32'd1346269);
        wait_out(100, cyc);
        check("t1_latency",     32'(cyc), 32'd20);
        check("t1_out_number",  out_number, 32'd1346269);
        check("t1_out_flags",   32'(out_flags), 32'd3);
        check("t1_out_timeout", 32'(out_timeout), 32'd0);
        check("t1_enable_emit", 32'(ana_enable), 32'd0);
        check("t1_restarts",    32'(restart_cnt - rc), 32'd1);
        consume;
        check("t1_done_count",  32'(done_count), 32'd1);
        check("t1_busy_idle",   32'(busy), 32'd0);
        check("t1_valid_drop",  32'(out_valid), 32'd0);

        // ---- back-to-back burst of five, out_ready held ----
        reset = 1'b0;
        step;
        reset = 1'b1;
        stub_n     = 3;
        stub_flags = 3'b101;
        base       = got_q.size();
        fc         = full_cycles;
        rc         = restart_cnt;
        out_ready  = 1'b1;
        for (int i = 0; i < 5; i++) push(words[i]);
        g = 0;
        while (done_count != 16'd5 && g < 300) begin
            step;
            g++;
        end
        out_ready = 1'b0;
        check("t2_done_count",  32'(done_count), 32'd5);
        check("t2_saw_full",    32'(full_cycles > fc), 32'd1);
        check("t2_restarts",    32'(restart_cnt - rc), 32'd5);
        check("t2_result_cnt",  32'(got_q.size() - base), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (base + i < got_q.size()) check("t2_order", got_q[base + i], words[i]);
        end

        // ---- backpressure ----
        stub_n     = 5;
        stub_flags = 3'b110;
        rc         = restart_cnt;
        push(32'd832040);
        push(32'd13469);
        wait_out(100, cyc);
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step;
            if (!out_valid || out_number != 32'd832040 || out_flags != 3'b110) stable = 1'b0;
        end
        check("t3_stable",      32'(stable), 32'd1);
        check("t3_out_number",  out_number, 32'd832040);
        check("t3_no_launch",   32'(restart_cnt - rc), 32'd1);
        consume;
        wait_out(100, cyc);
        check("t3_second_num",  out_number, 32'd13469);
        check("t3_restarts",    32'(restart_cnt - rc), 32'd2);
        consume;

        // ---- timeout then normal completion ----
        stub_n     = 0;
        stub_flags = 3'b111;
        push(32'd13469);
        push(32'd1669);
        wait_restart;
        check("t4_restart",     32'(ana_restart), 32'd1);
        wait_out(100, cyc);
        check("t4_to_latency",  32'(cyc), 32'(TO + 3));
        check("t4_timeout",     32'(out_timeout), 32'd1);
        check("t4_to_flags",    32'(out_flags), 32'd0);
        check("t4_to_number",   out_number, 32'd13469);
        stub_n = 4;
        consume;
        wait_out(100, cyc);
        check("t4_ok_timeout",  32'(out_timeout), 32'd0);
        check("t4_ok_flags",    32'(out_flags), 32'd7);
        check("t4_ok_number",   out_number, 32'd1669);
        consume;

        // ---- stale ready masked by SETTLE ----
        stub_n     = 10;
        stub_stale = 1'b1;
        stub_flags = 3'b001;
        push(32'd1669);
        wait_restart;
        wait_out(100, cyc);
        check("t5_latency",     32'(cyc), 32'd11);
        check("t5_out_number",  out_number, 32'd1669);
        check("t5_out_flags",   32'(out_flags), 32'd1);
        check("t5_timeout",     32'(out_timeout), 32'd0);
        consume;
        stub_stale = 1'b0;

        // ---- reset during WAIT with three words queued ----
        stub_n = 0;
        for (int i = 0; i < 4; i++) push(words[i]);
        for (int i = 0; i < 5; i++) step;
        check("t6_pre_enable",  32'(ana_enable), 32'd1);
        reset = 1'b0;
        step;
        reset = 1'b1;
        check("t6_in_ready",    32'(in_ready), 32'd1);
        check("t6_out_valid",   32'(out_valid), 32'd0);
        check("t6_done_count",  32'(done_count), 32'd0);
        check("t6_ana_number",  ana_number, 32'd0);
        check("t6_busy",        32'(busy), 32'd0);
        rc = restart_cnt;
        for (int i = 0; i < 10; i++) step;
        check("t6_no_restart",  32'(restart_cnt - rc), 32'd0);
        stub_n     = 3;
        stub_flags = 3'b010;
        push(32'd1187811);
        wait_out(100, cyc);
        check("t6_new_number",  out_number, 32'd1187811);
        check("t6_new_flags",   32'(out_flags), 32'd2);
        consume;
        check("t6_done_after",  32'(done_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
